// File: rtl/sam_mouse.sv
// sam_mouse: SAM Coupe mouse emulation fed by PS/2 mouse packets.
// Ports: clk_sys system clock; rst_n async active-low reset;
//        ps2_clk/ps2_data raw PS/2 mouse lines; io_rd level high during a mouse-port read;
//        dout nibble for the current read index; active set after the first valid packet;
//        rx_err one-cycle pulse on a PS/2 framing or parity error.
module sam_mouse #(
  parameter int TIMEOUT = 4800,
  parameter int PKT_GAP = 192000,
  parameter int FILT    = 8
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       io_rd,
  output logic [3:0] dout,
  output logic       active,
  output logic       rx_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(PKT_GAP + 1);
  localparam int FW = $clog2(FILT + 1);
  logic [1:0] ck_s, dt_s;
  logic ck_f, fall, gap;
  logic [FW-1:0] fcnt;
  logic [GW-1:0] gcnt;
  logic [3:0] bit_cnt;
  logic [8:0] shr;
  logic byte_vld, done, latch, rd_d, rd_rise, rd_fall;
  logic [7:0] byte_q, b0, b1;
  logic [1:0] pkt_cnt;
  logic [2:0] btn;
  logic signed [8:0] dx, dy;
  logic signed [11:0] acc_x, acc_y, lat_x, lat_y, nx_x, nx_y;
  logic signed [12:0] sx, sy;
  logic [3:0] idx, cur_idx;
  logic [TW-1:0] tmo;
  // Falling edge of the filtered clock: the filter is about to flip from 1 to 0.
  assign fall = ck_f && !ck_s[1] && fcnt == FW'(FILT - 1);
  assign gap  = gcnt == GW'(PKT_GAP);
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ck_s <= 2'b11;
      dt_s <= 2'b11;
      ck_f <= 1'b1;
      fcnt <= '0;
      gcnt <= '0;
    end else begin
      ck_s <= {ck_s[0], ps2_clk};
      dt_s <= {dt_s[0], ps2_data};
      if (ck_s[1] == ck_f) fcnt <= '0;
      else if (fcnt == FW'(FILT - 1)) begin
        ck_f <= ck_s[1];
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
      gcnt <= fall ? '0 : gap ? gcnt : gcnt + 1'b1;
    end
  end
  // Bit 0 is the start bit, bits 1..9 shift data+parity, bit 10 is the stop bit.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      shr      <= '0;
      byte_vld <= 1'b0;
      byte_q   <= '0;
      rx_err   <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      rx_err   <= 1'b0;
      if (fall) begin
        if (bit_cnt == 4'd0) begin
          if (dt_s[1]) rx_err <= 1'b1;
          else bit_cnt <= 4'd1;
        end else if (bit_cnt < 4'd10) begin
          shr     <= {dt_s[1], shr[8:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          bit_cnt <= '0;
          if (^shr && dt_s[1]) begin
            byte_vld <= 1'b1;
            byte_q   <= shr[7:0];
          end else rx_err <= 1'b1;
        end
      end else if (gap) bit_cnt <= '0;
    end
  end
  assign done = byte_vld && pkt_cnt == 2'd2;
  // Overflow replaces the 9-bit delta with the extreme of its sign.
  assign dx = b0[6] ? (b0[4] ? 9'h100 : 9'h0FF) : {b0[4], b1};
  assign dy = b0[7] ? (b0[5] ? 9'h100 : 9'h0FF) : {b0[5], byte_q};
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
      b0      <= '0;
      b1      <= '0;
      btn     <= '0;
      active  <= 1'b0;
    end else if (rx_err || gap) pkt_cnt <= '0;
    else if (byte_vld) begin
      if (pkt_cnt == 2'd0) begin
        if (byte_q[3]) begin
          b0      <= byte_q;
          pkt_cnt <= 2'd1;
        end
      end else if (pkt_cnt == 2'd1) begin
        b1      <= byte_q;
        pkt_cnt <= 2'd2;
      end else begin
        pkt_cnt <= '0;
        btn     <= b0[2:0];
        active  <= 1'b1;
      end
    end
  end
  function automatic logic signed [11:0] sat(input logic signed [12:0] v);
    return v > 13'sd2047 ? 12'h7FF : v < -13'sd2048 ? 12'h800 : v[11:0];
  endfunction
  assign rd_rise = io_rd && !rd_d;
  assign rd_fall = !io_rd && rd_d;
  // An expired timeout reads as index 0, even in the same cycle as a new read edge.
  assign cur_idx = tmo == '0 ? 4'd0 : idx;
  assign latch   = rd_rise && cur_idx == 4'd0;
  // Latching empties the accumulator; a packet landing in that cycle starts the new total.
  always_comb begin
    sx   = (latch ? 13'sd0 : 13'(acc_x)) + (done ? 13'(dx) : 13'sd0);
    sy   = (latch ? 13'sd0 : 13'(acc_y)) + (done ? 13'(dy) : 13'sd0);
    nx_x = sat(sx);
    nx_y = sat(sy);
  end
  // The timeout reloads while io_rd is high so dout cannot change mid-read.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rd_d  <= 1'b0;
      idx   <= '0;
      tmo   <= '0;
      acc_x <= '0;
      acc_y <= '0;
      lat_x <= '0;
      lat_y <= '0;
    end else begin
      rd_d  <= io_rd;
      tmo   <= io_rd ? TW'(TIMEOUT) : tmo == '0 ? '0 : tmo - 1'b1;
      idx   <= rd_fall ? (cur_idx == 4'd9 ? 4'd9 : cur_idx + 4'd1) : cur_idx;
      acc_x <= nx_x;
      acc_y <= nx_y;
      if (latch) begin
        lat_x <= acc_x;
        lat_y <= acc_y;
      end
    end
  end
  always_comb begin
    case (cur_idx)
      4'd1:    dout = {1'b1, ~btn};
      4'd2:    dout = lat_y[11:8];
      4'd3:    dout = lat_y[7:4];
      4'd4:    dout = lat_y[3:0];
      4'd5:    dout = lat_x[11:8];
      4'd6:    dout = lat_x[7:4];
      4'd7:    dout = lat_x[3:0];
      default: dout = 4'hF;
    endcase
  end
endmodule

// File: tb/tb_sam_mouse.sv
// tb_sam_mouse: randomized self-checking bench for sam_mouse against a packet-level model.
module tb_sam_mouse;
  localparam int TO = 100, GAP = 1000, FL = 4, H = 8;
  logic clk_sys = 0, rst_n = 0, ps2_clk = 1, ps2_data = 1, io_rd = 0;
  logic [3:0] dout;
  logic active, rx_err;
  int checks = 0, errors = 0, cyc = 0, err_pulses = 0, falls = 0, last_rd = 0;
  int m_ax, m_ay, m_lx, m_ly, m_idx;
  logic [2:0] m_btn;
  logic m_act;
  sam_mouse #(.TIMEOUT(TO), .PKT_GAP(GAP), .FILT(FL)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .io_rd(io_rd), .dout(dout), .active(active), .rx_err(rx_err)
  );
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc++;
  always @(posedge clk_sys) if (rx_err) err_pulses++;
  function automatic int clamp(input int v);
    return v > 2047 ? 2047 : v < -2048 ? -2048 : v;
  endfunction
  function automatic int delta(input logic ov, input logic sg, input logic [7:0] b);
    return ov ? (sg ? -256 : 255) : (sg ? int'(b) - 256 : int'(b));
  endfunction
  function automatic logic [3:0] nib(input int i);
    logic [11:0] x, y;
    x = m_lx[11:0];
    y = m_ly[11:0];
    case (i)
      0: return 4'hF;
      1: return {1'b1, ~m_btn};
      2: return y[11:8];
      3: return y[7:4];
      4: return y[3:0];
      5: return x[11:8];
      6: return x[7:4];
      7: return x[3:0];
      default: return 4'hF;
    endcase
  endfunction
  task automatic m_clear();
    m_ax = 0; m_ay = 0; m_lx = 0; m_ly = 0; m_idx = 0; m_btn = 0; m_act = 0;
  endtask
  task automatic send_frame(input logic [7:0] d, input int nbits, input logic bad_par, input logic bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (H) @(negedge clk_sys);
      ps2_clk = 0;
      falls++;
      repeat (H) @(negedge clk_sys);
      ps2_clk = 1;
    end
    ps2_data = 1;
    repeat (2 * H) @(negedge clk_sys);
  endtask
  task automatic pkt_raw(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 11, 0, 0);
    send_frame(b1, 11, 0, 0);
    send_frame(b2, 11, 0, 0);
  endtask
  task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    pkt_raw(b0, b1, b2);
    m_ax = clamp(m_ax + delta(b0[6], b0[4], b1));
    m_ay = clamp(m_ay + delta(b0[7], b0[5], b2));
    m_btn = b0[2:0];
    m_act = 1;
  endtask
  task automatic rd(output logic [3:0] v);
    @(negedge clk_sys);
    io_rd = 1;
    repeat (3) @(negedge clk_sys);
    v = dout;
    io_rd = 0;
    last_rd = cyc;
    repeat (8) @(negedge clk_sys);
  endtask
  task automatic mrd(output logic [3:0] e, output logic [3:0] g);
    if (cyc - last_rd > TO + 4) m_idx = 0;
    if (m_idx == 0) begin
      m_lx = m_ax; m_ly = m_ay; m_ax = 0; m_ay = 0;
    end
    e = nib(m_idx);
    rd(g);
    if (m_idx < 9) m_idx++;
  endtask
  task automatic pause(input int n);
    repeat (n) @(negedge clk_sys);
  endtask
  task automatic test_reset();
    rst_n = 0;
    pause(3);
    checks++; if (dout !== 4'hF) begin errors++; $display("FAIL reset_dout got=%h exp=F", dout); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_rx_err got=%b exp=0", rx_err); end
    m_clear();
    rst_n = 1;
    pause(4);
  endtask
  task automatic test_idle_reads();
    logic [3:0] e, g;
    for (int i = 0; i < 9; i++) begin
      mrd(e, g);
      checks++; if (g !== e) begin errors++; $display("FAIL idle_read%0d got=%h exp=%h", i, g, e); end
    end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL idle_active got=%b exp=0", active); end
  endtask
  task automatic test_basic();
    logic [3:0] e, g;
    pkt(8'h28, 8'h05, 8'hFD);
    for (int i = 0; i < 8; i++) begin
      mrd(e, g);
      checks++; if (g !== e) begin errors++; $display("FAIL basic_read%0d got=%h exp=%h", i, g, e); end
    end
    checks++; if (active !== m_act) begin errors++; $display("FAIL basic_active got=%b exp=%b", active, m_act); end
  endtask
  task automatic test_buttons();
    logic [3:0] e, g;
    pkt(8'h09, 8'h00, 8'h00);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 2; i++) begin
        mrd(e, g);
        checks++; if (g !== e) begin errors++; $display("FAIL buttons_pass%0d_read%0d got=%h exp=%h", r, i, g, e); end
      end
      pause(TO * 3);
    end
    for (int p = 0; p < 4; p++) pkt(8'h18, 8'hFF, 8'h00);
    for (int i = 0; i < 8; i++) begin
      mrd(e, g);
      checks++; if (g !== e) begin errors++; $display("FAIL neg_x_read%0d got=%h exp=%h", i, g, e); end
    end
  endtask
  task automatic test_errors();
    logic [3:0] e, g;
    int e0;
    e0 = err_pulses;
    send_frame(8'h08, 11, 0, 0);
    send_frame(8'h05, 11, 1, 0);
    checks++; if (err_pulses !== e0 + 1) begin errors++; $display("FAIL parity_err pulses=%0d exp=%0d", err_pulses - e0, 1); end
    send_frame(8'hFD, 11, 0, 1);
    checks++; if (err_pulses !== e0 + 2) begin errors++; $display("FAIL stop_err pulses=%0d exp=%0d", err_pulses - e0, 2); end
    pkt(8'h3A, 8'h81, 8'h10);
    for (int i = 0; i < 8; i++) begin
      mrd(e, g);
      checks++; if (g !== e) begin errors++; $display("FAIL after_err_read%0d got=%h exp=%h", i, g, e); end
    end
  endtask
  task automatic test_gap();
    logic [3:0] e, g;
    int e0;
    e0 = err_pulses;
    send_frame(8'h0F, 11, 0, 0);
    send_frame(8'h33, 4, 0, 0);
    pause(GAP + 100);
    pkt(8'h1C, 8'hF0, 8'h07);
    checks++; if (err_pulses !== e0) begin errors++; $display("FAIL gap_no_err pulses=%0d exp=0", err_pulses - e0); end
    for (int i = 0; i < 8; i++) begin
      mrd(e, g);
      checks++; if (g !== e) begin errors++; $display("FAIL gap_read%0d got=%h exp=%h", i, g, e); end
    end
  endtask
  task automatic test_random();
    logic [3:0] e, g;
    logic [7:0] b0;
    int np, nr;
    for (int r = 0; r < 6; r++) begin
      np = $urandom_range(1, 3);
      for (int p = 0; p < np; p++) begin
        b0 = 8'($urandom);
        b0[3] = 1'b1;
        if ($urandom_range(0, 4) != 0) b0[7:6] = 2'b00;
        pkt(b0, 8'($urandom), 8'($urandom));
      end
      nr = $urandom_range(1, 9);
      for (int i = 0; i < nr; i++) begin
        mrd(e, g);
        checks++; if (g !== e) begin errors++; $display("FAIL rand%0d_read%0d got=%h exp=%h", r, i, g, e); end
      end
      if ($urandom_range(0, 1) == 1) pause(TO + 50);
    end
  endtask
  task automatic test_saturation();
    logic [3:0] e, g;
    for (int p = 0; p < 40; p++) pkt(8'hE8, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 8; i++) begin
      mrd(e, g);
      checks++; if (g !== e) begin errors++; $display("FAIL sat_read%0d got=%h exp=%h", i, g, e); end
    end
    checks++; if (m_lx !== 2047 || m_ly !== -2048) begin errors++; $display("FAIL sat_model x=%0d y=%0d exp=2047/-2048", m_lx, m_ly); end
  endtask
  task automatic test_reset_mid_frame();
    logic [3:0] e, g;
    send_frame(8'h08, 5, 0, 0);
    rst_n = 0;
    pause(3);
    checks++; if (active !== 1'b0 || dout !== 4'hF) begin errors++; $display("FAIL midrst active=%b dout=%h exp=0/F", active, dout); end
    m_clear();
    rst_n = 1;
    pause(4);
    pkt(8'h2D, 8'h11, 8'hEE);
    for (int i = 0; i < 8; i++) begin
      mrd(e, g);
      checks++; if (g !== e) begin errors++; $display("FAIL midrst_read%0d got=%h exp=%h", i, g, e); end
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0] v [8];
    logic [11:0] x1, x2;
    int target, t;
    pause(TO * 3);
    for (int i = 0; i < 8; i++) rd(v[i]);
    for (int off = 0; off < 15; off++) begin
      pause(TO * 3);
      target = falls + 33;
      fork
        pkt_raw(8'h08, 8'h03, 8'h00);
        begin
          t = 0;
          while (falls < target && t < 5000) begin
            @(negedge clk_sys);
            t++;
          end
          if (t >= 5000) begin
            errors++;
            $display("FAIL b2b_wait off=%0d falls=%0d exp=%0d", off, falls, target);
          end
          repeat (off) @(negedge clk_sys);
          for (int i = 0; i < 8; i++) rd(v[i]);
        end
      join
      x1 = {v[5], v[6], v[7]};
      pause(TO * 3);
      for (int i = 0; i < 8; i++) rd(v[i]);
      x2 = {v[5], v[6], v[7]};
      checks++; if (x1 + x2 !== 12'd3) begin errors++; $display("FAIL b2b_sum off=%0d got=%0d exp=3", off, x1 + x2); end
      checks++; if (x1 !== 12'd0 && x1 !== 12'd3) begin errors++; $display("FAIL b2b_split off=%0d first=%0d exp=0or3", off, x1); end
    end
  endtask
  initial begin
    test_reset();
    test_idle_reads();
    test_basic();
    test_buttons();
    test_errors();
    test_gap();
    test_random();
    test_saturation();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
